// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and index-width helper.
package arb_types;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of a channel index; a 1-bit index is kept even for degenerate channel counts.
  function automatic int idx_width(input int num_ch);
    return (num_ch < 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Rotating priority picker: finds the first requester at or above ptr (modulo NUM_CH).
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  logic [2*NUM_CH-1:0] dbl_req;
  logic [NUM_CH-1:0]   rot_req;
  logic [IDX_W-1:0]    rot_idx;
  logic [IDX_W:0]      sum;

  // Rotating the doubled vector right by ptr puts channel ptr at bit 0.
  assign dbl_req = {req, req};
  assign rot_req = NUM_CH'(dbl_req >> ptr);

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rot_idx = '0;
    valid   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        rot_idx = IDX_W'(i);
        valid   = 1'b1;
      end
    end
  end

  // Rotate the winning position back into the channel numbering.
  assign sum = {1'b0, rot_idx} + {1'b0, ptr};
  assign idx = (sum >= (IDX_W+1)'(NUM_CH)) ? IDX_W'(sum - (IDX_W+1)'(NUM_CH))
                                           : sum[IDX_W-1:0];
  assign gnt = valid ? (NUM_CH'(1) << idx) : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel memory arbiter: latches one winning request and holds it on the memory port until mem_resp.
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  localparam int MBE_W     = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH*MBE_W-1:0]  ch_mbe,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [MBE_W-1:0]         mem_mbe,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_resp
);

  localparam int IDX_W = idx_width(NUM_CH);

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MBE_W-1:0]  mbe;
  } req_t;

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  next_ptr;
  logic [IDX_W-1:0]  pick_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [NUM_CH-1:0] pick_gnt;
  logic [NUM_CH-1:0] ch_req;
  logic              pick_valid;
  req_t              sel_req;
  req_t              req_q;

  assign ch_req   = ch_read | ch_write;
  // Fixed priority is round-robin with the search always starting at channel 0.
  assign pick_ptr = (FIXED_PRIO != 0) ? '0 : ptr;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req   (ch_req),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // One-hot mux of the winner's fields; read wins when a channel raises both ops.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_gnt[i]) begin
        sel_req.read  = ch_read[i];
        sel_req.write = ch_write[i] & ~ch_read[i];
        sel_req.addr  = ch_addr[i*ADDR_W +: ADDR_W];
        sel_req.wdata = ch_wdata[i*DATA_W +: DATA_W];
        sel_req.mbe   = ch_mbe[i*MBE_W +: MBE_W];
      end
    end
  end

  assign next_ptr = (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + IDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      req_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            req_q <= sel_req;
            grant <= pick_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            req_q.read  <= 1'b0;
            req_q.write <= 1'b0;
            state       <= IDLE;
            if (FIXED_PRIO == 0) ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_read  = req_q.read;
  assign mem_write = req_q.write;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_mbe   = req_q.mbe;

  assign ch_rdata = mem_rdata;
  assign ch_resp  = (mem_resp && state == BUSY) ? (NUM_CH'(1) << grant) : '0;

endmodule
